// File: rtl/chunk_head_masked.sv
// Walks the enabled config IDs of one chunk request in ascending order and emits
// one memory offset per ID: a per-ID base plus strided, shuffled block/accumulation terms.
module chunk_head_masked #(
    parameter int BW     = 16,
    parameter int N_ICFG = 4,
    parameter int VDIM   = 4,
    parameter int DIM    = 5,
    parameter int SF_BW  = 3,
    parameter int SS_BW  = 4,
    parameter int ID_BW  = $clog2(N_ICFG + 1),
    parameter int DIM_BW = $clog2(DIM)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_abofs_rdy,
    output logic                                        i_abofs_ack,
    input  logic                                        i_which,
    input  logic [VDIM-1:0][BW-1:0]                     i_bofs,
    input  logic [VDIM-1:0][BW-1:0]                     i_aofs,
    input  logic [ID_BW-1:0]                            i_beg,
    input  logic [ID_BW-1:0]                            i_end,
    input  logic [N_ICFG-1:0]                           i_id_en,
    input  logic [N_ICFG-1:0][DIM-1:0][BW-1:0]          i_global_mofs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0]     i_bshufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0]     i_ashufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]      i_bstrides_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]      i_bstrides_shamt,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]      i_astrides_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]      i_astrides_shamt,
    output logic                                        o_mofs_rdy,
    input  logic                                        o_mofs_ack,
    output logic                                        o_which,
    output logic [DIM-1:0][BW-1:0]                      o_mofs,
    output logic [ID_BW-1:0]                            o_id,
    output logic                                        o_last
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q;
    logic                    o_mofs_rdy_q;
    logic                    o_which_q;
    logic [DIM-1:0][BW-1:0]  o_mofs_q;
    logic [ID_BW-1:0]        o_id_q;
    logic                    o_last_q;

    logic [N_ICFG-1:0]       elig;
    logic [ID_BW-1:0]        search_start;
    logic                    id_found;
    logic [ID_BW-1:0]        id_d;
    logic                    last_d;
    logic [DIM-1:0][BW-1:0]  mofs_d;

    logic [DIM-1:0][BW-1:0]        sel_gmofs;
    logic [VDIM-1:0][DIM_BW-1:0]   sel_bshuf;
    logic [VDIM-1:0][DIM_BW-1:0]   sel_ashuf;
    logic [VDIM-1:0][SF_BW-1:0]    sel_bfrac;
    logic [VDIM-1:0][SS_BW-1:0]    sel_bshamt;
    logic [VDIM-1:0][SF_BW-1:0]    sel_afrac;
    logic [VDIM-1:0][SS_BW-1:0]    sel_ashamt;
    logic [VDIM-1:0][BW-1:0]       bprod;
    logic [VDIM-1:0][BW-1:0]       bterm;
    logic [VDIM-1:0][BW-1:0]       aprod;
    logic [VDIM-1:0][BW-1:0]       aterm;

    // An ID is eligible when enabled and below the exclusive range end.
    genvar gi;
    generate
        for (gi = 0; gi < N_ICFG; gi++) begin : g_elig
            assign elig[gi] = i_id_en[gi] && (ID_BW'(gi) < i_end);
        end
    endgenerate

    function automatic logic any_from(input logic [N_ICFG-1:0] m, input logic [ID_BW-1:0] s);
        any_from = 1'b0;
        for (int k = 0; k < N_ICFG; k++)
            if (m[k] && (ID_BW'(k) >= s)) any_from = 1'b1;
    endfunction

    function automatic logic [ID_BW-1:0] first_from(input logic [N_ICFG-1:0] m,
                                                    input logic [ID_BW-1:0] s);
        first_from = '0;
        for (int k = N_ICFG - 1; k >= 0; k--)
            if (m[k] && (ID_BW'(k) >= s)) first_from = ID_BW'(k);
    endfunction

    // o_id_q + 1 cannot overflow: o_id_q <= N_ICFG-1 and ID_BW holds N_ICFG.
    assign search_start = (state_q == BUSY) ? (o_id_q + ID_BW'(1)) : i_beg;
    assign id_found     = any_from(elig, search_start);
    assign id_d         = first_from(elig, search_start);
    assign last_d       = !any_from(elig, id_d + ID_BW'(1));

    always_comb begin
        sel_gmofs  = '0;
        sel_bshuf  = '0;
        sel_ashuf  = '0;
        sel_bfrac  = '0;
        sel_bshamt = '0;
        sel_afrac  = '0;
        sel_ashamt = '0;
        for (int k = 0; k < N_ICFG; k++) begin
            if (id_d == ID_BW'(k)) begin
                sel_gmofs  = i_global_mofs[k];
                sel_bshuf  = i_bshufs[k];
                sel_ashuf  = i_ashufs[k];
                sel_bfrac  = i_bstrides_frac[k];
                sel_bshamt = i_bstrides_shamt[k];
                sel_afrac  = i_astrides_frac[k];
                sel_ashamt = i_astrides_shamt[k];
            end
        end
    end

    // Products and shifts are evaluated at BW bits, so they wrap modulo 2^BW.
    generate
        for (gi = 0; gi < VDIM; gi++) begin : g_term
            assign bprod[gi] = i_bofs[gi] * BW'(sel_bfrac[gi]);
            assign bterm[gi] = bprod[gi] << sel_bshamt[gi];
            assign aprod[gi] = i_aofs[gi] * BW'(sel_afrac[gi]);
            assign aterm[gi] = aprod[gi] << sel_ashamt[gi];
        end
    endgenerate

    // Shuffle targets at or beyond DIM never match a dimension and drop out.
    always_comb begin
        mofs_d = sel_gmofs;
        for (int d = 0; d < DIM; d++) begin
            for (int v = 0; v < VDIM; v++) begin
                if (sel_bshuf[v] == DIM_BW'(d)) mofs_d[d] = mofs_d[d] + bterm[v];
                if (sel_ashuf[v] == DIM_BW'(d)) mofs_d[d] = mofs_d[d] + aterm[v];
            end
        end
    end

    assign i_abofs_ack = i_rst &&
                         (((state_q == IDLE) && i_abofs_rdy && !id_found) ||
                          ((state_q == BUSY) && o_mofs_ack && o_last_q));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            o_mofs_rdy_q <= 1'b0;
            o_which_q    <= 1'b0;
            o_mofs_q     <= '0;
            o_id_q       <= '0;
            o_last_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_abofs_rdy && id_found) begin
                        state_q      <= BUSY;
                        o_mofs_rdy_q <= 1'b1;
                        o_which_q    <= i_which;
                        o_mofs_q     <= mofs_d;
                        o_id_q       <= id_d;
                        o_last_q     <= last_d;
                    end
                end
                BUSY: begin
                    if (o_mofs_ack) begin
                        if (o_last_q) begin
                            state_q      <= IDLE;
                            o_mofs_rdy_q <= 1'b0;
                        end else begin
                            o_mofs_q <= mofs_d;
                            o_id_q   <= id_d;
                            o_last_q <= last_d;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    o_mofs_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mofs_rdy = o_mofs_rdy_q;
    assign o_which    = o_which_q;
    assign o_mofs     = o_mofs_q;
    assign o_id       = o_id_q;
    assign o_last     = o_last_q;

endmodule

// File: tb/tb_chunk_head_masked.sv
// Scoreboard bench for chunk_head_masked: expected outputs are built from the
// ID-range/enable rules and the offset formula, then checked by a separate monitor.
module tb_chunk_head_masked;

    localparam int BW     = 16;
    localparam int N_ICFG = 4;
    localparam int VDIM   = 4;
    localparam int DIM    = 5;
    localparam int SF_BW  = 3;
    localparam int SS_BW  = 4;
    localparam int ID_BW  = $clog2(N_ICFG + 1);
    localparam int DIM_BW = $clog2(DIM);

    logic                                    i_clk = 1'b0;
    logic                                    i_rst;
    logic                                    i_abofs_rdy;
    logic                                    i_abofs_ack;
    logic                                    i_which;
    logic [VDIM-1:0][BW-1:0]                 i_bofs;
    logic [VDIM-1:0][BW-1:0]                 i_aofs;
    logic [ID_BW-1:0]                        i_beg;
    logic [ID_BW-1:0]                        i_end;
    logic [N_ICFG-1:0]                       i_id_en;
    logic [N_ICFG-1:0][DIM-1:0][BW-1:0]      i_global_mofs;
    logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_bshufs;
    logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_ashufs;
    logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_bstrides_frac;
    logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_bstrides_shamt;
    logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_astrides_frac;
    logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_astrides_shamt;
    logic                                    o_mofs_rdy;
    logic                                    o_mofs_ack;
    logic                                    o_which;
    logic [DIM-1:0][BW-1:0]                  o_mofs;
    logic [ID_BW-1:0]                        o_id;
    logic                                    o_last;

    chunk_head_masked #(
        .BW(BW), .N_ICFG(N_ICFG), .VDIM(VDIM), .DIM(DIM), .SF_BW(SF_BW), .SS_BW(SS_BW),
        .ID_BW(ID_BW), .DIM_BW(DIM_BW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_abofs_rdy(i_abofs_rdy), .i_abofs_ack(i_abofs_ack), .i_which(i_which),
        .i_bofs(i_bofs), .i_aofs(i_aofs), .i_beg(i_beg), .i_end(i_end), .i_id_en(i_id_en),
        .i_global_mofs(i_global_mofs), .i_bshufs(i_bshufs), .i_ashufs(i_ashufs),
        .i_bstrides_frac(i_bstrides_frac), .i_bstrides_shamt(i_bstrides_shamt),
        .i_astrides_frac(i_astrides_frac), .i_astrides_shamt(i_astrides_shamt),
        .o_mofs_rdy(o_mofs_rdy), .o_mofs_ack(o_mofs_ack), .o_which(o_which),
        .o_mofs(o_mofs), .o_id(o_id), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                     id;
        bit                     which;
        bit                     last;
        logic [DIM-1:0][BW-1:0] mofs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   full_ack = 1'b0;
    bit   stall = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference offset for one ID, in wide integer arithmetic reduced at the end.
    function automatic logic [DIM-1:0][BW-1:0] model_mofs(input int k);
        longint acc;
        for (int d = 0; d < DIM; d++) begin
            acc = longint'(i_global_mofs[k][d]);
            for (int v = 0; v < VDIM; v++) begin
                if (int'(i_bshufs[k][v]) == d)
                    acc += (longint'(i_bofs[v]) * longint'(i_bstrides_frac[k][v])) << i_bstrides_shamt[k][v];
                if (int'(i_ashufs[k][v]) == d)
                    acc += (longint'(i_aofs[v]) * longint'(i_astrides_frac[k][v])) << i_astrides_shamt[k][v];
            end
            model_mofs[d] = acc[BW-1:0];
        end
    endfunction

    function automatic int build_expected(input int beg, input int fin,
                                          input logic [N_ICFG-1:0] en, input bit which);
        int   ids[$];
        exp_t e;
        for (int k = 0; k < N_ICFG; k++)
            if (k >= beg && k < fin && en[k]) ids.push_back(k);
        foreach (ids[i]) begin
            e.id    = ids[i];
            e.which = which;
            e.last  = (i == ids.size() - 1);
            e.mofs  = model_mofs(ids[i]);
            sb.push_back(e);
        end
        return ids.size();
    endfunction

    task automatic zero_cfg();
        i_bofs = '0; i_aofs = '0; i_global_mofs = '0;
        i_bshufs = '0; i_ashufs = '0;
        i_bstrides_frac = '0; i_bstrides_shamt = '0;
        i_astrides_frac = '0; i_astrides_shamt = '0;
    endtask

    task automatic rand_cfg();
        for (int v = 0; v < VDIM; v++) begin
            i_bofs[v] = BW'($urandom);
            i_aofs[v] = BW'($urandom);
        end
        for (int k = 0; k < N_ICFG; k++) begin
            for (int d = 0; d < DIM; d++) i_global_mofs[k][d] = BW'($urandom);
            for (int v = 0; v < VDIM; v++) begin
                i_bshufs[k][v]         = DIM_BW'($urandom);
                i_ashufs[k][v]         = DIM_BW'($urandom);
                i_bstrides_frac[k][v]  = SF_BW'($urandom);
                i_bstrides_shamt[k][v] = SS_BW'($urandom);
                i_astrides_frac[k][v]  = SF_BW'($urandom);
                i_astrides_shamt[k][v] = SS_BW'($urandom);
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rdy"},   128'(o_mofs_rdy), 128'(0));
        chk({tag, "_which"}, 128'(o_which), 128'(0));
        chk({tag, "_mofs"},  128'(o_mofs), 128'(0));
        chk({tag, "_id"},    128'(o_id), 128'(0));
        chk({tag, "_last"},  128'(o_last), 128'(0));
        chk({tag, "_ack"},   128'(i_abofs_ack), 128'(0));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_chunk(input int beg, input int fin, input logic [N_ICFG-1:0] en,
                             input bit which, input bit full, input int chk_dim, input int chk_val);
        int n;
        int cyc;
        bit got;
        i_beg = ID_BW'(beg);
        i_end = ID_BW'(fin);
        i_id_en = en;
        i_which = which;
        full_ack = full;
        n = build_expected(beg, fin, en, which);
        $display("chunk beg=%0d end=%0d en=%b which=%0d outputs=%0d", beg, fin, en, which, n);
        i_abofs_rdy = 1'b1;
        #1;
        chk("accept_cycle_ack", 128'(i_abofs_ack), 128'(n == 0));
        if (n == 0) begin
            @(negedge i_clk);
            chk("empty_no_output", 128'(o_mofs_rdy), 128'(0));
        end else begin
            @(negedge i_clk);
            chk("first_output_latency", 128'(o_mofs_rdy), 128'(1));
            if (chk_dim >= 0) chk("directed_mofs", 128'(o_mofs[chk_dim]), 128'(chk_val));
            #1;
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 200) begin
                if (i_abofs_ack) got = 1'b1;
                else begin
                    @(negedge i_clk);
                    #1;
                    cyc++;
                end
            end
            chk("chunk_ack_seen", 128'(got), 128'(1));
            chk("scoreboard_drained_at_ack", 128'(sb.size()), 128'(0));
            if (full) chk("burst_cycles", 128'(cyc), 128'(n - 1));
            @(negedge i_clk);
            if (!got) begin
                i_rst = 1'b0;
                sb.delete();
                @(negedge i_clk);
                i_rst = 1'b1;
            end
        end
        i_abofs_rdy = 1'b0;
        full_ack = 1'b0;
    endtask

    // Monitor: checks the presented output against the scoreboard head every cycle
    // (so stalled outputs must hold) and pops it when the transfer takes place.
    initial begin
        exp_t e;
        o_mofs_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst !== 1'b1 || o_mofs_rdy !== 1'b1) begin
                o_mofs_ack = 1'b0;
            end else if (sb.size() == 0) begin
                chk("unexpected_output", 128'(o_mofs_rdy), 128'(0));
                o_mofs_ack = 1'b1;
            end else begin
                e = sb[0];
                chk("out_id",    128'(o_id), 128'(e.id));
                chk("out_which", 128'(o_which), 128'(e.which));
                chk("out_last",  128'(o_last), 128'(e.last));
                chk("out_mofs",  128'(o_mofs), 128'(e.mofs));
                o_mofs_ack = full_ack ? 1'b1 : (stall ? 1'b0 : ($urandom_range(0, 3) != 0));
                if (o_mofs_ack) begin
                    $display("out id=%0d last=%0d mofs=%h", o_id, o_last, o_mofs);
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DIM-1:0][BW-1:0] held;
        int b, f;
        i_rst = 1'b1;
        i_abofs_rdy = 1'b0;
        i_which = 1'b0;
        i_beg = '0;
        i_end = '0;
        i_id_en = '0;
        zero_cfg();
        #1 i_rst = 1'b0;
        #3;
        chk_outputs_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        // Full enable, ack held high: four back-to-back outputs.
        rand_cfg();
        run_chunk(0, 4, 4'b1111, 1'b1, 1'b1, -1, 0);
        // Sparse enable: only ids 1 and 3.
        rand_cfg();
        run_chunk(0, 4, 4'b1010, 1'b0, 1'b1, -1, 0);
        // Empty chunks: zero-width range, no enables, begin beyond table, begin past end.
        run_chunk(2, 2, 4'b1111, 1'b1, 1'b0, -1, 0);
        run_chunk(0, 4, 4'b0000, 1'b0, 1'b0, -1, 0);
        run_chunk(5, 7, 4'b1111, 1'b1, 1'b0, -1, 0);
        run_chunk(3, 1, 4'b1111, 1'b0, 1'b0, -1, 0);
        // Stride arithmetic: 100 + (3*2)<<1 + 5*1 = 117 on dimension 1.
        zero_cfg();
        i_bofs[0] = 16'd3; i_bstrides_frac[0][0] = 3'd2; i_bstrides_shamt[0][0] = 4'd1;
        i_bshufs[0][0] = 3'd1;
        i_aofs[0] = 16'd5; i_astrides_frac[0][0] = 3'd1; i_ashufs[0][0] = 3'd1;
        i_global_mofs[0][1] = 16'd100;
        run_chunk(0, 1, 4'b0001, 1'b0, 1'b1, 1, 117);
        // Wrap: 0xFFFF + 1 on dimension 3 of id 2.
        zero_cfg();
        i_global_mofs[2][3] = 16'hFFFF;
        i_aofs[1] = 16'd1; i_astrides_frac[2][1] = 3'd1; i_ashufs[2][1] = 3'd3;
        run_chunk(0, 4, 4'b0100, 1'b1, 1'b1, 3, 0);

        // Stall three cycles, then reset mid-chunk.
        rand_cfg();
        stall = 1'b1;
        i_beg = 3'd0; i_end = 3'd4; i_id_en = 4'b1111; i_which = 1'b1;
        void'(build_expected(0, 4, 4'b1111, 1'b1));
        i_abofs_rdy = 1'b1;
        @(negedge i_clk);
        chk("stall_first_output", 128'(o_mofs_rdy), 128'(1));
        held = o_mofs;
        repeat (3) begin
            @(negedge i_clk);
            #1;
            chk("stall_no_ack", 128'(i_abofs_ack), 128'(0));
        end
        chk("stall_mofs_hold", 128'(o_mofs), 128'(held));
        #2 i_rst = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        i_beg = 3'd2; i_end = 3'd2;
        #1;
        chk("empty_ack_in_reset", 128'(i_abofs_ack), 128'(0));
        sb.delete();
        stall = 1'b0;
        @(negedge i_clk);
        i_abofs_rdy = 1'b0;
        i_rst = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            #1;
            chk("post_reset_idle", 128'(o_mofs_rdy), 128'(0));
            chk("post_reset_no_ack", 128'(i_abofs_ack), 128'(0));
        end
        @(negedge i_clk);

        // Randomised chunks with random back-pressure.
        for (int t = 0; t < 40; t++) begin
            rand_cfg();
            b = $urandom_range(0, 4);
            f = $urandom_range(0, 7);
            run_chunk(b, f, N_ICFG'($urandom), 1'($urandom), 1'b0, -1, 0);
            repeat ($urandom_range(0, 1)) @(negedge i_clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_head_masked.md
CHUNK_HEAD_MASKED -- requirements
Module: chunk_head_masked

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BW, 16, offset word width.
- N_ICFG, 4, number of config entries.
- VDIM, 4, vector dimensions of the input offsets.
- DIM, 5, memory dimensions of the output offset.
- SF_BW, 3, stride fraction width.
- SS_BW, 4, stride shift-amount width.
- ID_BW equals clog2(N_ICFG+1).
- DIM_BW equals clog2(DIM).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, the only clock.
- i_rst, in, 1, asynchronous active-low reset.
- i_abofs_rdy, in, 1, chunk request valid.
- i_abofs_ack, out, 1, chunk consumed.
- i_which, in, 1, tag.
- i_bofs, in, BW x VDIM, block offset.
- i_aofs, in, BW x VDIM, accumulation offset.
- i_beg, in, ID_BW, first ID of the range.
- i_end, in, ID_BW, exclusive end of the range.
- i_id_en, in, N_ICFG, per-ID enable mask.
- i_global_mofs, in, BW x N_ICFG x DIM, per-ID base offset.
- i_bshufs, in, DIM_BW x N_ICFG x VDIM.
- i_ashufs, in, DIM_BW x N_ICFG x VDIM.
- i_bstrides_frac, in, SF_BW x N_ICFG x VDIM.
- i_bstrides_shamt, in, SS_BW x N_ICFG x VDIM.
- i_astrides_frac, in, SF_BW x N_ICFG x VDIM.
- i_astrides_shamt, in, SS_BW x N_ICFG x VDIM.
- o_mofs_rdy, out, 1, output valid.
- o_mofs_ack, in, 1, output taken.
- o_which, out, 1, registered tag.
- o_mofs, out, BW x DIM, memory offset.
- o_id, out, ID_BW, config ID of this output.
- o_last, out, 1, final output of the chunk.

Function
REQ-003 Both handshakes SHALL use the rdy/ack protocol: a transfer occurs in a cycle where ack is high, and ack SHALL only be high while rdy is high.
REQ-004 The producer SHALL hold i_abofs_rdy and all i_* data stable from rdy high until i_abofs_ack; the config inputs and i_id_en SHALL be static outside IDLE.
REQ-005 The block SHALL have two states, IDLE and BUSY; o_mofs_rdy SHALL be 1 exactly in BUSY.
REQ-006 The ID search SHALL be combinational: nxt(s) is the lowest ID k with s <= k < i_end, k < N_ICFG and i_id_en[k] = 1; otherwise nxt(s) is none.
REQ-007 IDLE with i_abofs_rdy=1 and nxt(i_beg)=none SHALL assert i_abofs_ack combinationally in that cycle, emit no output and stay in IDLE (empty chunk).
REQ-008 IDLE with i_abofs_rdy=1 and nxt(i_beg)=k SHALL register the chunk's first output for ID k (k into o_id, the tag into o_which, o_last = (nxt(k+1) = none)), SHALL go to BUSY, and SHALL NOT ack the input.
REQ-009 BUSY with o_mofs_ack=1 and o_last=0 SHALL register the output for nxt(o_id+1) in the same cycle and stay in BUSY (one output per cycle).
REQ-010 BUSY with o_mofs_ack=1 and o_last=1 SHALL assert i_abofs_ack in that cycle and go to IDLE; the next chunk costs exactly one IDLE cycle.
REQ-011 BUSY with o_mofs_ack=0 SHALL hold all outputs unchanged.
REQ-012 For ID k, o_mofs[d] SHALL be the sum of:
- i_global_mofs[k][d];
- every i_bofs[v]*i_bstrides_frac[k][v] shifted left by i_bstrides_shamt[k][v], over v with i_bshufs[k][v]=d;
- every i_aofs[v]*i_astrides_frac[k][v] shifted left by i_astrides_shamt[k][v], over v with i_ashufs[k][v]=d.
REQ-013 Every product, shift and sum SHALL be truncated modulo 2^BW (wrap, no saturation); shuffle values >= DIM SHALL contribute nothing.
REQ-014 i_beg >= i_end, or i_beg >= N_ICFG, SHALL be treated as an empty chunk per REQ-007.
REQ-015 Latency from input accept (IDLE) to the first o_mofs_rdy SHALL be 1 cycle.

Reset
REQ-016 When i_rst is low, the block SHALL asynchronously enter IDLE and clear o_mofs_rdy, o_which, o_mofs (all elements), o_id and o_last to 0; i_abofs_ack SHALL be 0 while in reset.
REQ-017 Reset asserted mid-chunk SHALL abandon the chunk with no ack; after release the block SHALL wait in IDLE for a fresh request.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Scenario 1: N_ICFG=4, beg=0, end=4, en=1111, ack held high -> o_id 0,1,2,3 in 4 consecutive cycles; o_last only with id 3; i_abofs_ack in that same cycle.
- Scenario 2: en=1010, beg=0, end=4 -> outputs only for ids 1 and 3; o_last=1 with id 3.
- Scenario 3: beg=2, end=2, or en=0000 -> i_abofs_ack in the accept cycle; o_mofs_rdy stays 0.
- Scenario 4: bofs[0]=3, bstrides_frac=2, bstrides_shamt=1, bshuf=1, aofs[0]=5, astrides_frac=1, ashuf=1, global_mofs[1]=100, all other inputs 0 -> o_mofs[1] = 100+12+5 = 117.
- Scenario 5: BW=16, global_mofs=0xFFFF, addend 1 -> o_mofs = 0x0000 (wrap).
- Scenario 6: o_mofs_ack withheld for 3 cycles, then reset pulsed mid-chunk -> outputs stable while stalled; after reset all outputs are 0, the state is IDLE and no i_abofs_ack is issued.
